// File: rtl/fifo_unpacker.sv
// Pops wide words from a FIFO read port and streams them out as narrow valid/ready chunks.
// Define FIFO_UNPACK_MSB_FIRST_EN to emit the most significant chunk of each word first.
module fifo_unpacker #(
  parameter int data_wd = 32,
  parameter int out_wd  = 8,
  parameter int cnt_wd  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [data_wd-1:0] fifo_rd_data,
  output logic              fifo_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [out_wd-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int RATIO = data_wd / out_wd;
  localparam logic [cnt_wd-1:0] LAST_CNT = cnt_wd'(RATIO - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_reg;
  logic [data_wd-1:0]  word_reg;
  logic [cnt_wd-1:0]   cnt_reg;
  logic [cnt_wd-1:0]   sel;
  logic [out_wd-1:0]   chunk [RATIO];
  logic                last_accept;

  // Split the held word into chunk slots so the output is a plain mux on the counter.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_chunk
      assign chunk[gi] = word_reg[gi*out_wd +: out_wd];
    end
  endgenerate

`ifdef FIFO_UNPACK_MSB_FIRST_EN
  assign sel = LAST_CNT - cnt_reg;
`else
  assign sel = cnt_reg;
`endif

  assign out_valid   = (state_reg == SHIFT);
  assign busy        = out_valid;
  assign out_data    = chunk[sel];
  assign out_last    = out_valid && (cnt_reg == LAST_CNT);
  assign last_accept = out_valid && out_ready && out_last;

  // Popping on the final handshake lets the next word follow without a bubble.
  assign fifo_rd = !rst && !fifo_empty && ((state_reg == IDLE) || last_accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fifo_rd) begin
            word_reg  <= fifo_rd_data;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (!out_last) begin
              cnt_reg <= cnt_reg + cnt_wd'(1);
            end else if (!fifo_empty) begin
              word_reg <= fifo_rd_data;
              cnt_reg  <= '0;
            end else begin
              cnt_reg   <= '0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
